// File: rtl/fetch_queue_pc.sv
// fetch_queue_pc: PC generator feeding a small fetch FIFO drained by decode via valid/ready
module fetch_queue_pc #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4,
  parameter int FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [XLEN-1:0]             iaddr,
  input  logic [XLEN-1:0]             idata,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        out_valid,
  output logic [XLEN-1:0]             out_pc,
  output logic [XLEN-1:0]             out_instr,
  input  logic                        out_ready,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [AW:0] DEPTH = (AW+1)'(FQ_DEPTH);
  logic [XLEN-1:0] pc;
  logic [2*XLEN-1:0] mem [FQ_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic pop, push;
  assign iaddr = pc;
  assign fq_count = count;
  assign out_valid = count != '0;
  assign {out_pc, out_instr} = mem[rd_ptr];
  assign pop = out_valid & out_ready;
  assign push = !redirect_valid & ((count < DEPTH) | pop);
  // PC, pointers and occupancy; redirect flushes and reloads, otherwise advance on push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~(STEP - 1'b1);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) pc <= pc + STEP;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // Capture the fetched word alongside its PC
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= {pc, idata};
  end
endmodule

// File: tb/tb_fetch_queue_pc.sv
// tb_fetch_queue_pc: directed plus randomized checks against a queue-based fetch model
module tb_fetch_queue_pc;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 0;
  logic reset = 1;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = '0;
  logic out_ready = 0;
  logic [31:0] iaddr, idata, out_pc, out_instr;
  logic out_valid;
  logic [2:0] fq_count;
  logic [31:0] hi_iaddr, hi_idata, hi_out_pc, hi_out_instr;
  logic hi_out_valid;
  logic [2:0] hi_fq_count;
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] q [$];
  logic [31:0] m_pc = '0;

  always #5 clk = ~clk;
  assign idata = iaddr ^ K;
  assign hi_idata = hi_iaddr ^ K;

  fetch_queue_pc dut (
    .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .fq_count(fq_count)
  );

  fetch_queue_pc #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk(clk), .reset(reset), .iaddr(hi_iaddr), .idata(hi_idata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(hi_out_valid), .out_pc(hi_out_pc), .out_instr(hi_out_instr),
    .out_ready(1'b1), .fq_count(hi_fq_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("fq_count", 32'(fq_count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("iaddr", iaddr, m_pc);
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0][63:32]);
      chk("out_instr", out_instr, q[0][31:0]);
    end
  endtask

  task automatic step(input bit rst_i, input bit rv, input logic [31:0] rp, input bit rdy);
    bit p;
    reset = rst_i;
    redirect_valid = rv;
    redirect_pc = rp;
    out_ready = rdy;
    @(posedge clk);
    if (rst_i) begin
      q.delete();
      m_pc = '0;
    end else begin
      p = q.size() != 0 && rdy;
      if (p) void'(q.pop_front());
      if (rv) begin
        q.delete();
        m_pc = rp & ~32'h3;
      end else if (q.size() < 4) begin
        q.push_back({m_pc, m_pc ^ K});
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    // reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("rst_count", 32'(fq_count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_iaddr", iaddr, 0);
    chk("hi_rst_iaddr", hi_iaddr, 32'hFFFF_FFF8);
    // streaming with out_ready=1, plus wrap on the high-RESET_PC instance
    step(0, 0, 0, 1);
    chk("t1_pc0", out_pc, 0);
    chk("hi_pc0", hi_out_pc, 32'hFFFF_FFF8);
    step(0, 0, 0, 1);
    chk("t1_pc1", out_pc, 4);
    chk("hi_pc1", hi_out_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("t1_pc2", out_pc, 8);
    chk("hi_pc2", hi_out_pc, 32'h0);
    chk("hi_instr2", hi_out_instr, K);
    step(0, 0, 0, 1);
    chk("t1_pc3", out_pc, 12);
    chk("t1_cnt", 32'(fq_count), 1);
    // fill with out_ready=0 from release
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    chk("t2_full", 32'(fq_count), 4);
    chk("t2_iaddr", iaddr, 16);
    chk("t2_head", out_pc, 0);
    step(0, 0, 0, 1);
    chk("t2_popfull_cnt", 32'(fq_count), 4);
    chk("t2_popfull_head", out_pc, 4);
    chk("t2_popfull_iaddr", iaddr, 20);
    // redirect with 3 queued entries
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("t3_pre", 32'(fq_count), 3);
    step(0, 1, 32'h0000_0103, 1);
    chk("t3_cnt", 32'(fq_count), 0);
    chk("t3_valid", 32'(out_valid), 0);
    chk("t3_iaddr", iaddr, 32'h100);
    step(0, 0, 0, 1);
    chk("t3_pc", out_pc, 32'h100);
    // back-to-back redirects
    step(0, 1, 32'h200, 0);
    step(0, 1, 32'h300, 0);
    chk("t4_cnt", 32'(fq_count), 0);
    step(0, 0, 0, 0);
    chk("t4_pc", out_pc, 32'h300);
    // reset while full with redirect asserted
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("t6_full", 32'(fq_count), 4);
    step(1, 1, 32'h500, 1);
    chk("t6_cnt", 32'(fq_count), 0);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_iaddr", iaddr, 0);
    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(63) == 0, $urandom_range(7) == 0,
           $urandom_range(3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom,
           $urandom_range(2) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
